// File: rtl/rvv_pkg.sv
// Shared definitions for the vector destination collector: FSM state
// encoding, legal chunk-width codes and the byte-enable helper.
package rvv_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_WRITE   = 2'd2,
      ST_DONE    = 2'd3
   } coll_state_e;

   // log2 of the chunk size in bits
   localparam logic [2:0] CW_8  = 3'd3;
   localparam logic [2:0] CW_16 = 3'd4;
   localparam logic [2:0] CW_32 = 3'd5;
   localparam logic [2:0] CW_64 = 3'd6;

   // Widest supported register (VLEN = 512) in bytes.
   localparam int unsigned MAX_BYTES = 64;

   // Byte i is enabled when it lies below the active byte count.
   function automatic logic [MAX_BYTES-1:0] be_from_nbytes(input logic [7:0] nbytes);
      logic [MAX_BYTES-1:0] be;
      be = '0;
      for (int i = 0; i < MAX_BYTES; i++) begin
         if (8'(i) < nbytes) begin
            be[i] = 1'b1;
         end else begin
            be[i] = 1'b0;
         end
      end
      return be;
   endfunction

endpackage

// File: rtl/rvv_chunk_merge.sv
// Combinational insertion of one lane-result chunk into the destination
// image: validates the chunk, then overwrites the covered bytes and marks
// them in the byte mask. Illegal chunks leave buffer and mask untouched.
module rvv_chunk_merge
   import rvv_pkg::*;
#(
   parameter int unsigned VLEN = 128
) (
   input  logic [VLEN-1:0]   buf_i,
   input  logic [VLEN/8-1:0] mask_i,
   input  logic [63:0]       data_i,
   input  logic [9:0]        index_i,
   input  logic [2:0]        width_i,
   input  logic [7:0]        nbytes_i,
   output logic [VLEN-1:0]   buf_o,
   output logic [VLEN/8-1:0] mask_o,
   output logic              illegal_o
);

   localparam int unsigned BYTES = VLEN / 8;

   logic [3:0]  span_s;       // chunk size in bytes
   logic        width_ok_s;
   logic [10:0] end_bit_s;    // first bit past the chunk
   logic [10:0] limit_bit_s;  // first bit past the active region
   logic [6:0]  rel_s;        // byte position relative to chunk start

   // Decode the chunk width code into a byte span.
   always_comb begin
      case (width_i)
         CW_8:    begin span_s = 4'd1; width_ok_s = 1'b1; end
         CW_16:   begin span_s = 4'd2; width_ok_s = 1'b1; end
         CW_32:   begin span_s = 4'd4; width_ok_s = 1'b1; end
         CW_64:   begin span_s = 4'd8; width_ok_s = 1'b1; end
         default: begin span_s = 4'd0; width_ok_s = 1'b0; end
      endcase
   end

   assign end_bit_s   = {1'b0, index_i} + {4'b0000, span_s, 3'b000};
   assign limit_bit_s = {nbytes_i, 3'b000};
   assign illegal_o   = (index_i[2:0] != 3'b000) || !width_ok_s ||
                        (end_bit_s > limit_bit_s);

   // Overwrite every destination byte covered by a legal chunk.
   always_comb begin
      buf_o  = buf_i;
      mask_o = mask_i;
      rel_s  = 7'd0;
      for (int b = 0; b < BYTES; b++) begin
         // bytes below the chunk wrap to large values and fall outside the span
         rel_s = 7'(b) - index_i[9:3];
         if (!illegal_o && (rel_s < {3'b000, span_s})) begin
            buf_o[b*8 +: 8] = data_i[{rel_s[2:0], 3'b000} +: 8];
            mask_o[b]       = 1'b1;
         end else begin
            buf_o[b*8 +: 8] = buf_i[b*8 +: 8];
            mask_o[b]       = mask_i[b];
         end
      end
   end

endmodule

// File: rtl/rvv_vd_collector.sv
// Collects lane-width ALU result chunks into one VLEN-wide destination image
// and commits it to the VRF in a single byte-enabled write.
module rvv_vd_collector
   import rvv_pkg::*;
#(
   parameter int unsigned VLEN   = 128,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] vd_addr,
   input  logic [7:0]        nbytes,
   input  logic              flush,
   input  logic              chunk_valid,
   output logic              chunk_ready,
   input  logic [63:0]       chunk_data,
   input  logic [9:0]        chunk_index,
   input  logic [2:0]        chunk_width,
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [VLEN-1:0]   wr_data,
   output logic [VLEN/8-1:0] wr_be,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int unsigned BYTES   = VLEN / 8;
   localparam logic [7:0]  BYTES_B = 8'(BYTES);

   coll_state_e       state_q, state_d;
   logic [VLEN-1:0]   buf_q, buf_d;
   logic [BYTES-1:0]  mask_q, mask_d;
   logic              err_q, err_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        nb_q, nb_d;
   logic              wr_valid_q, done_q, busy_q, ready_q;
   logic [BYTES-1:0]  wr_be_q;

   logic [7:0]           nb_clamp_s;
   logic [MAX_BYTES-1:0] be_full_s;
   logic [BYTES-1:0]     be_s;
   logic [VLEN-1:0]      m_buf_s;
   logic [BYTES-1:0]     m_mask_s;
   logic                 m_illegal_s;

   assign nb_clamp_s = (nbytes > BYTES_B) ? BYTES_B : nbytes;
   assign be_full_s  = be_from_nbytes(nb_q);
   assign be_s       = be_full_s[BYTES-1:0];

   if (BYTES < MAX_BYTES) begin : g_be_tail
      logic unused_be_s;
      assign unused_be_s = ^be_full_s[MAX_BYTES-1:BYTES];
   end

   rvv_chunk_merge #(.VLEN(VLEN)) u_merge (
      .buf_i     (buf_q),
      .mask_i    (mask_q),
      .data_i    (chunk_data),
      .index_i   (chunk_index),
      .width_i   (chunk_width),
      .nbytes_i  (nb_q),
      .buf_o     (m_buf_s),
      .mask_o    (m_mask_s),
      .illegal_o (m_illegal_s)
   );

   // Next-state and datapath update; flush outranks chunks and wr_ready.
   always_comb begin
      state_d = state_q;
      buf_d   = buf_q;
      mask_d  = mask_q;
      err_d   = err_q;
      addr_d  = addr_q;
      nb_d    = nb_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               addr_d  = vd_addr;
               nb_d    = nb_clamp_s;
               buf_d   = '0;
               mask_d  = '0;
               err_d   = 1'b0;
               state_d = (nb_clamp_s == 8'd0) ? ST_DONE : ST_COLLECT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_COLLECT: begin
            if (flush) begin
               buf_d   = '0;
               mask_d  = '0;
               state_d = ST_IDLE;
            end else if (chunk_valid) begin
               // merge leaves buffer and mask unchanged on an illegal chunk
               buf_d  = m_buf_s;
               mask_d = m_mask_s;
               err_d  = err_q | m_illegal_s;
               if ((m_mask_s & be_s) == be_s) begin
                  state_d = ST_WRITE;
               end else begin
                  state_d = ST_COLLECT;
               end
            end else begin
               state_d = ST_COLLECT;
            end
         end
         ST_WRITE: begin
            if (flush) begin
               buf_d   = '0;
               mask_d  = '0;
               state_d = ST_IDLE;
            end else if (wr_ready) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_WRITE;
            end
         end
         ST_DONE: begin
            if (flush) begin
               buf_d  = '0;
               mask_d = '0;
            end else begin
               mask_d = mask_q;
            end
            state_d = ST_IDLE;
         end
         default: begin
            buf_d   = '0;
            mask_d  = '0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Collector FSM: state, image buffer and outputs registered from next state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         buf_q      <= '0;
         mask_q     <= '0;
         err_q      <= 1'b0;
         addr_q     <= '0;
         nb_q       <= 8'd0;
         wr_valid_q <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         ready_q    <= 1'b0;
         wr_be_q    <= '0;
      end else begin
         state_q    <= state_d;
         buf_q      <= buf_d;
         mask_q     <= mask_d;
         err_q      <= err_d;
         addr_q     <= addr_d;
         nb_q       <= nb_d;
         wr_valid_q <= (state_d == ST_WRITE);
         done_q     <= (state_d == ST_DONE);
         busy_q     <= (state_d != ST_IDLE);
         ready_q    <= (state_d == ST_COLLECT);
         wr_be_q    <= (state_d == ST_WRITE) ? be_s : '0;
      end
   end

   // Tail bytes of the buffer are never written, so gating yields a clean image.
   assign wr_data     = buf_q & {VLEN{wr_valid_q}};
   assign wr_valid    = wr_valid_q;
   assign wr_be       = wr_be_q;
   assign wr_addr     = addr_q;
   assign chunk_ready = ready_q;
   assign busy        = busy_q;
   assign done        = done_q;
   assign err         = err_q;

endmodule

// File: tb/tb_rvv_vd_collector.sv
// Directed self-checking bench for rvv_vd_collector (VLEN = 128).
module tb_rvv_vd_collector;
   import rvv_pkg::*;

   logic         clk;
   logic         reset;
   logic         start;
   logic [4:0]   vd_addr;
   logic [7:0]   nbytes;
   logic         flush;
   logic         chunk_valid;
   logic         chunk_ready;
   logic [63:0]  chunk_data;
   logic [9:0]   chunk_index;
   logic [2:0]   chunk_width;
   logic         wr_valid;
   logic         wr_ready;
   logic [4:0]   wr_addr;
   logic [127:0] wr_data;
   logic [15:0]  wr_be;
   logic         busy;
   logic         done;
   logic         err;

   int n_tests = 0;
   int n_fail  = 0;

   rvv_vd_collector #(.VLEN(128), .ADDR_W(5)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .vd_addr     (vd_addr),
      .nbytes      (nbytes),
      .flush       (flush),
      .chunk_valid (chunk_valid),
      .chunk_ready (chunk_ready),
      .chunk_data  (chunk_data),
      .chunk_index (chunk_index),
      .chunk_width (chunk_width),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .wr_be       (wr_be),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic [4:0] a, input logic [7:0] nb);
      vd_addr = a;
      nbytes  = nb;
      start   = 1'b1;
      tick();
      start   = 1'b0;
   endtask

   task automatic send_chunk(input logic [63:0] d, input logic [9:0] idx, input logic [2:0] w);
      chunk_data  = d;
      chunk_index = idx;
      chunk_width = w;
      chunk_valid = 1'b1;
      tick();
      chunk_valid = 1'b0;
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; vd_addr = 5'd0; nbytes = 8'd0; flush = 1'b0;
      chunk_valid = 1'b0; chunk_data = 64'd0; chunk_index = 10'd0;
      chunk_width = 3'd0; wr_ready = 1'b0;

      // reset state
      #12;
      check("rst_ctrl", 128'({wr_valid, chunk_ready, busy, done, err}), 128'(5'b00000));
      check("rst_data", wr_data, 128'd0);
      check("rst_be",   128'(wr_be), 128'(16'h0000));
      check("rst_addr", 128'(wr_addr), 128'(5'd0));
      @(posedge clk); #1;
      reset = 1'b0;
      tick();

      // T1: four 32-bit chunks, full register
      do_start(5'd3, 8'd16);
      check("t1_busy",  128'(busy), 128'(1'b1));
      check("t1_ready", 128'(chunk_ready), 128'(1'b1));
      send_chunk(64'h11111111, 10'd0,  CW_32);
      send_chunk(64'h22222222, 10'd32, CW_32);
      send_chunk(64'h33333333, 10'd64, CW_32);
      check("t1_novalid", 128'(wr_valid), 128'(1'b0));
      send_chunk(64'h44444444, 10'd96, CW_32);
      check("t1_valid", 128'(wr_valid), 128'(1'b1));
      check("t1_rdy0",  128'(chunk_ready), 128'(1'b0));
      check("t1_data",  wr_data, 128'h44444444_33333333_22222222_11111111);
      check("t1_be",    128'(wr_be), 128'(16'hFFFF));
      check("t1_addr",  128'(wr_addr), 128'(5'd3));
      wr_ready = 1'b1;
      tick();
      wr_ready = 1'b0;
      check("t1_done",   128'(done), 128'(1'b1));
      check("t1_vdrop",  128'(wr_valid), 128'(1'b0));
      check("t1_dzero",  wr_data, 128'd0);
      tick();
      check("t1_done0",  128'(done), 128'(1'b0));
      check("t1_idle",   128'(busy), 128'(1'b0));

      // T2: partial register, out-of-order 16-bit chunks, back-pressure
      do_start(5'd7, 8'd6);
      send_chunk(64'hDEADBEEF_0000CCCC, 10'd32, CW_16);
      send_chunk(64'h12340000_0000AAAA, 10'd0,  CW_16);
      send_chunk(64'hFFFFFFFF_FFFFBBBB, 10'd16, CW_16);
      for (int k = 0; k < 4; k++) begin
         check("t2_valid", 128'(wr_valid), 128'(1'b1));
         check("t2_data",  wr_data, 128'h0000CCCC_BBBBAAAA);
         check("t2_be",    128'(wr_be), 128'(16'h003F));
         check("t2_addr",  128'(wr_addr), 128'(5'd7));
         if (k == 3) wr_ready = 1'b1;
         tick();
      end
      wr_ready = 1'b0;
      check("t2_done", 128'(done), 128'(1'b1));
      tick();
      check("t2_done0", 128'(done), 128'(1'b0));

      // T3: illegal chunks dropped, err sticky until next start
      do_start(5'd9, 8'd8);
      send_chunk(64'hFFFFFFFF, 10'd12, CW_32);
      check("t3_err_mis", 128'(err), 128'(1'b1));
      check("t3_rdy",     128'(chunk_ready), 128'(1'b1));
      send_chunk(64'hEE, 10'd120, CW_8);
      check("t3_err_oob", 128'(err), 128'(1'b1));
      check("t3_nov_oob", 128'(wr_valid), 128'(1'b0));
      send_chunk(64'hFFFFFFFF_FFFFFFFF, 10'd0, 3'd7);
      check("t3_nov_w7",  128'(wr_valid), 128'(1'b0));
      send_chunk(64'hFFFFFFFF_FFFFFFFF, 10'd0, 3'd2);
      check("t3_nov_w2",  128'(wr_valid), 128'(1'b0));
      send_chunk(64'h01234567_89ABCDEF, 10'd0, CW_64);
      check("t3_valid", 128'(wr_valid), 128'(1'b1));
      check("t3_data",  wr_data, 128'h01234567_89ABCDEF);
      check("t3_be",    128'(wr_be), 128'(16'h00FF));
      wr_ready = 1'b1;
      tick();
      wr_ready = 1'b0;
      check("t3_done", 128'(done), 128'(1'b1));
      tick();
      check("t3_err_keep", 128'(err), 128'(1'b1));

      // T4: empty instruction
      do_start(5'd2, 8'd0);
      check("t4_errclr", 128'(err), 128'(1'b0));
      check("t4_done",   128'(done), 128'(1'b1));
      check("t4_busy",   128'(busy), 128'(1'b1));
      check("t4_nov",    128'(wr_valid), 128'(1'b0));
      check("t4_nordy",  128'(chunk_ready), 128'(1'b0));
      tick();
      check("t4_done0",  128'(done), 128'(1'b0));
      check("t4_busy0",  128'(busy), 128'(1'b0));

      // T5: flush mid-collection, then a fresh instruction
      do_start(5'd4, 8'd16);
      send_chunk(64'hAAAAAAAA, 10'd0,  CW_32);
      send_chunk(64'hBBBBBBBB, 10'd32, CW_32);
      flush = 1'b1;
      chunk_valid = 1'b1; chunk_data = 64'h99999999; chunk_index = 10'd64; chunk_width = CW_32;
      tick();
      flush = 1'b0;
      chunk_valid = 1'b0;
      check("t5_fl_busy", 128'(busy), 128'(1'b0));
      check("t5_fl_rdy",  128'(chunk_ready), 128'(1'b0));
      check("t5_fl_nov",  128'(wr_valid), 128'(1'b0));
      chunk_valid = 1'b1;
      tick();
      chunk_valid = 1'b0;
      check("t5_nodone",  128'(done), 128'(1'b0));
      check("t5_idlechk", 128'(busy), 128'(1'b0));
      do_start(5'd5, 8'd200);
      send_chunk(64'h33333333, 10'd64, CW_32);
      send_chunk(64'h44444444, 10'd96, CW_32);
      check("t5_maskclr", 128'(wr_valid), 128'(1'b0));
      start = 1'b1; vd_addr = 5'd31; nbytes = 8'd4;
      tick();
      start = 1'b0;
      check("t5_ign_busy", 128'(busy), 128'(1'b1));
      send_chunk(64'h55555555, 10'd0,  CW_32);
      check("t5_ign_nb", 128'(wr_valid), 128'(1'b0));
      send_chunk(64'h66666666, 10'd32, CW_32);
      check("t5_valid", 128'(wr_valid), 128'(1'b1));
      check("t5_data",  wr_data, 128'h44444444_33333333_66666666_55555555);
      check("t5_be",    128'(wr_be), 128'(16'hFFFF));
      check("t5_addr",  128'(wr_addr), 128'(5'd5));
      wr_ready = 1'b1;
      tick();
      wr_ready = 1'b0;
      check("t5_done", 128'(done), 128'(1'b1));
      tick();

      // T6: asynchronous reset during WRITE
      do_start(5'd6, 8'd8);
      send_chunk(64'hCAFEF00D_12345678, 10'd0, CW_64);
      check("t6_valid", 128'(wr_valid), 128'(1'b1));
      #2;
      reset = 1'b1;
      #1;
      check("t6_ctrl", 128'({wr_valid, chunk_ready, busy, done, err}), 128'(5'b00000));
      check("t6_data", wr_data, 128'd0);
      check("t6_be",   128'(wr_be), 128'(16'h0000));
      check("t6_addr", 128'(wr_addr), 128'(5'd0));
      @(posedge clk); #1;
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("t6_rdy0", 128'({chunk_ready, wr_valid, busy}), 128'(3'b000));
      end
      do_start(5'd1, 8'd8);
      check("t6_restart", 128'(chunk_ready), 128'(1'b1));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
